vdp_line_interrupt: RTL and testbench

Multi-channel raster line interrupt generator for the V9958-compatible VDP core. It generalises the single R#19/IE1/FH line interrupt into NUM_CH independent compare channels. Each channel has a vertical-scroll-adjusted compare, a repeat or one-shot mode, and a clear-on-read flag. The block sits between the video timing generator and the status/interrupt mux that drives `slot_intr`.

---
 rtl/vdp_line_int_pkg.sv | 16 +
 rtl/vdp_line_int_ch.sv | 71 +++++++
 rtl/vdp_line_interrupt.sv | 109 ++++++++++
 tb/tb_vdp_line_interrupt.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_line_int_pkg.sv
// Shared constants and types for the multi-channel raster line interrupt block.
// Optional per-channel miss counters are enabled with VDP_LINE_INT_MISS_COUNT_EN.
package vdp_line_int_pkg;

  localparam int MISS_W     = 4;
  localparam int MISS_MAX   = (1 << MISS_W) - 1;
  localparam int LINE_W_DEF = 9;

  typedef struct packed {
    logic [LINE_W_DEF-1:0] line_cmp;
    logic                  ie;
    logic                  oneshot;
    logic                  armed;
  } line_ch_cfg_t;

endpackage

// File: rtl/vdp_line_int_ch.sv
// One line-compare channel: match detection, sticky flag, one-shot arming and,
// with VDP_LINE_INT_MISS_COUNT_EN defined, a saturating missed-interrupt counter.
module vdp_line_int_ch
  import vdp_line_int_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [LINE_W-1:0] cmp_line,
  input  logic              wr,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_ie,
  input  logic              wr_oneshot,
  input  logic              rd,
  output logic              flag,
  output logic              ie
`ifdef VDP_LINE_INT_MISS_COUNT_EN
  ,
  output logic [MISS_W-1:0] miss
`endif
);

  logic [LINE_W-1:0] line_cmp;
  logic              oneshot;
  logic              armed;
  logic              match;

  // The match always sees the configuration from before a same-cycle write.
  assign match = line_start && (cmp_line == line_cmp) && armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cmp <= '0;
      ie       <= 1'b0;
      oneshot  <= 1'b0;
      armed    <= 1'b1;
      flag     <= 1'b0;
    end else begin
      // A write re-arms even when a one-shot match fires in the same cycle.
      if (wr) begin
        line_cmp <= wr_line;
        ie       <= wr_ie;
        oneshot  <= wr_oneshot;
        armed    <= 1'b1;
      end else if (match && oneshot) begin
        armed <= 1'b0;
      end
      // Set beats clear so a read racing a match never loses the event.
      if (match) begin
        flag <= 1'b1;
      end else if (rd) begin
        flag <= 1'b0;
      end
    end
  end

`ifdef VDP_LINE_INT_MISS_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss <= '0;
    end else if (rd) begin
      miss <= (match && flag) ? MISS_W'(1) : '0;
    end else if (match && flag && (miss != MISS_W'(MISS_MAX))) begin
      miss <= miss + MISS_W'(1);
    end
  end
`endif

endmodule

// File: rtl/vdp_line_interrupt.sv
// Multi-channel raster line interrupt generator (generalised R#19/IE1/FH).
// Define VDP_LINE_INT_MISS_COUNT_EN to add per-channel miss counters and status_miss.
module vdp_line_interrupt
  import vdp_line_int_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 9,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [LINE_W-1:0] v_count,
  input  logic [LINE_W-1:0] line_offset,
  input  logic              reg_wr,
  input  logic [CH_W-1:0]   reg_ch,
  input  logic [LINE_W-1:0] reg_line,
  input  logic              reg_ie,
  input  logic              reg_oneshot,
  input  logic              status_rd,
  input  logic [CH_W-1:0]   status_ch,
  output logic              status_flag,
  output logic [NUM_CH-1:0] int_flags,
  output logic              intr
`ifdef VDP_LINE_INT_MISS_COUNT_EN
  ,
  output logic [MISS_W-1:0] status_miss
`endif
);

  logic [LINE_W-1:0] cmp_line;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] rd_sel;
  logic [NUM_CH-1:0] flags;
  logic [NUM_CH-1:0] ies;
  logic              sel_flag;

  // Scrolled line number; the sum wraps naturally at LINE_W bits.
  assign cmp_line  = v_count + line_offset;
  assign int_flags = flags;

`ifdef VDP_LINE_INT_MISS_COUNT_EN
  logic [MISS_W-1:0] miss_ch [NUM_CH];
  logic [MISS_W-1:0] sel_miss;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // Out-of-range channel numbers match no decoder, so they write/clear nothing.
    assign wr_sel[gi] = reg_wr && (reg_ch == CH_W'(gi));
    assign rd_sel[gi] = status_rd && (status_ch == CH_W'(gi));

    vdp_line_int_ch #(
      .LINE_W(LINE_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .cmp_line   (cmp_line),
      .wr         (wr_sel[gi]),
      .wr_line    (reg_line),
      .wr_ie      (reg_ie),
      .wr_oneshot (reg_oneshot),
      .rd         (rd_sel[gi]),
      .flag       (flags[gi]),
      .ie         (ies[gi])
`ifdef VDP_LINE_INT_MISS_COUNT_EN
      ,
      .miss       (miss_ch[gi])
`endif
    );
  end

  always_comb begin
    sel_flag = 1'b0;
`ifdef VDP_LINE_INT_MISS_COUNT_EN
    sel_miss = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (status_ch == CH_W'(i)) begin
        sel_flag = flags[i];
`ifdef VDP_LINE_INT_MISS_COUNT_EN
        sel_miss = miss_ch[i];
`endif
      end
    end
  end

  // Status readback and interrupt request, one register stage after the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_flag <= 1'b0;
      intr        <= 1'b0;
    end else begin
      status_flag <= sel_flag;
      intr        <= |(flags & ies);
    end
  end

`ifdef VDP_LINE_INT_MISS_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_miss <= '0;
    end else begin
      status_miss <= sel_miss;
    end
  end
`endif

endmodule

// File: tb/tb_vdp_line_interrupt.sv
// Directed bench for vdp_line_interrupt (NUM_CH=2, LINE_W=9) with a per-cycle scoreboard.
module tb_vdp_line_interrupt;

  localparam int NUM_CH = 2;
  localparam int LINE_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              line_start;
  logic [LINE_W-1:0] v_count;
  logic [LINE_W-1:0] line_offset;
  logic              reg_wr;
  logic              reg_ch;
  logic [LINE_W-1:0] reg_line;
  logic              reg_ie;
  logic              reg_oneshot;
  logic              status_rd;
  logic              status_ch;
  logic              status_flag;
  logic [NUM_CH-1:0] int_flags;
  logic              intr;
`ifdef VDP_LINE_INT_MISS_COUNT_EN
  logic [3:0]        status_miss;
`endif

  vdp_line_interrupt #(
    .NUM_CH(NUM_CH),
    .LINE_W(LINE_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .v_count     (v_count),
    .line_offset (line_offset),
    .reg_wr      (reg_wr),
    .reg_ch      (reg_ch),
    .reg_line    (reg_line),
    .reg_ie      (reg_ie),
    .reg_oneshot (reg_oneshot),
    .status_rd   (status_rd),
    .status_ch   (status_ch),
    .status_flag (status_flag),
    .int_flags   (int_flags),
    .intr        (intr)
`ifdef VDP_LINE_INT_MISS_COUNT_EN
    ,
    .status_miss (status_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] flags;
    logic              sflag;
    logic              intr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [LINE_W-1:0] m_cmp [NUM_CH];
  logic [NUM_CH-1:0] m_ie, m_os, m_arm, m_flag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_cmp[i] = '0;
    m_ie   = '0;
    m_os   = '0;
    m_arm  = '1;
    m_flag = '0;
    sb.delete();
  endtask

  // Predict the post-edge outputs from the driven inputs, clock once, compare.
  task automatic cycle();
    exp_t              e;
    exp_t              got;
    logic [LINE_W-1:0] sum;
    logic [NUM_CH-1:0] nflag, narm;
    logic              match;
    sum   = v_count + line_offset;
    nflag = m_flag;
    narm  = m_arm;
    for (int i = 0; i < NUM_CH; i++) begin
      match = line_start && (sum == m_cmp[i]) && m_arm[i];
      if (match) nflag[i] = 1'b1;
      else if (status_rd && (status_ch == i)) nflag[i] = 1'b0;
      if (reg_wr && (reg_ch == i)) narm[i] = 1'b1;
      else if (match && m_os[i]) narm[i] = 1'b0;
    end
    e.sflag = m_flag[status_ch];
    e.intr  = |(m_flag & m_ie);
    e.flags = nflag;
    if (reg_wr) begin
      m_cmp[reg_ch] = reg_line;
      m_ie[reg_ch]  = reg_ie;
      m_os[reg_ch]  = reg_oneshot;
    end
    m_flag = nflag;
    m_arm  = narm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_int_flags", 32'(int_flags), 32'(got.flags));
    check("sb_status_flag", 32'(status_flag), 32'(got.sflag));
    check("sb_intr", 32'(intr), 32'(got.intr));
    line_start = 1'b0;
    reg_wr     = 1'b0;
    status_rd  = 1'b0;
  endtask

  task automatic do_write(input logic ch, input int line, input logic ie, input logic os);
    reg_wr      = 1'b1;
    reg_ch      = ch;
    reg_line    = LINE_W'(line);
    reg_ie      = ie;
    reg_oneshot = os;
    cycle();
  endtask

  task automatic do_line(input int vc);
    line_start = 1'b1;
    v_count    = LINE_W'(vc);
    cycle();
  endtask

  task automatic do_read(input logic ch);
    status_rd = 1'b1;
    status_ch = ch;
    cycle();
  endtask

  initial begin
    reset       = 1'b1;
    line_start  = 1'b0;
    v_count     = '0;
    line_offset = '0;
    reg_wr      = 1'b0;
    reg_ch      = 1'b0;
    reg_line    = '0;
    reg_ie      = 1'b0;
    reg_oneshot = 1'b0;
    status_rd   = 1'b0;
    status_ch   = 1'b0;
    model_reset();
    #12;
    check("rst_int_flags", 32'(int_flags), 32'h0);
    check("rst_status_flag", 32'(status_flag), 32'h0);
    check("rst_intr", 32'(intr), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Repeat channel 0 at line 69
    do_write(1'b0, 69, 1'b1, 1'b0);
    do_line(69);
    check("ch0_flag_t1", 32'(int_flags), 32'h1);
    cycle();
    check("ch0_intr_t2", 32'(intr), 32'h1);
    do_read(1'b0);
    check("ch0_status_read", 32'(status_flag), 32'h1);
    cycle();
    check("ch0_intr_cleared", 32'(intr), 32'h0);
    do_line(69);
    check("ch0_next_frame", 32'(int_flags), 32'h1);
    do_read(1'b0);
    cycle();

    // One-shot channel 1 at line 195
    do_write(1'b1, 195, 1'b1, 1'b1);
    do_line(195);
    check("ch1_oneshot_fire", 32'(int_flags), 32'h2);
    do_read(1'b1);
    check("ch1_status_read", 32'(status_flag), 32'h1);
    cycle();
    do_line(195);
    check("ch1_oneshot_disarmed", 32'(int_flags), 32'h0);
    do_write(1'b1, 195, 1'b1, 1'b1);
    do_line(195);
    check("ch1_rearm_fire", 32'(int_flags), 32'h2);
    do_read(1'b1);
    cycle();

    // Scrolled compare with wrap: 500 + 20 = 8 mod 512
    line_offset = LINE_W'(20);
    do_write(1'b0, 8, 1'b1, 1'b0);
    do_line(500);
    check("wrap_match", 32'(int_flags), 32'h1);
    do_read(1'b0);
    do_line(8);
    check("wrap_no_match", 32'(int_flags), 32'h0);

    // Read races a match on the same channel: set wins
    status_rd = 1'b1;
    status_ch = 1'b0;
    do_line(500);
    check("race_status_old", 32'(status_flag), 32'h0);
    check("race_flag_kept", 32'(int_flags[0]), 32'h1);
    do_read(1'b0);
    cycle();

    // Flag without enable, then enable it
    do_write(1'b0, 8, 1'b0, 1'b0);
    do_line(500);
    check("noie_flag", 32'(int_flags), 32'h1);
    cycle();
    check("noie_intr_low", 32'(intr), 32'h0);
    do_write(1'b0, 8, 1'b1, 1'b0);
    check("ie_write_t1", 32'(intr), 32'h0);
    cycle();
    check("ie_write_t2", 32'(intr), 32'h1);
    do_read(1'b0);
    cycle();

    // Write coinciding with a one-shot match keeps the channel armed
    do_write(1'b1, 195, 1'b1, 1'b1);
    reg_wr      = 1'b1;
    reg_ch      = 1'b1;
    reg_line    = LINE_W'(195);
    reg_ie      = 1'b1;
    reg_oneshot = 1'b1;
    do_line(175);
    check("wr_match_fire", 32'(int_flags), 32'h2);
    do_read(1'b1);
    do_line(175);
    check("wr_wins_rearm", 32'(int_flags), 32'h2);
    do_read(1'b1);
    do_line(175);
    check("oneshot_after_rearm", 32'(int_flags), 32'h0);

    // Asynchronous reset mid-frame with an interrupt pending
    do_line(500);
    cycle();
    check("pre_reset_intr", 32'(intr), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_int_flags", 32'(int_flags), 32'h0);
    check("async_rst_status_flag", 32'(status_flag), 32'h0);
    check("async_rst_intr", 32'(intr), 32'h0);
    model_reset();
    @(negedge clk);
    reset       = 1'b0;
    line_offset = '0;
    status_ch   = 1'b0;
    cycle();
    // Reset configuration: both channels compare line 0, armed, interrupts off
    do_line(0);
    check("rst_cfg_armed_line0", 32'(int_flags), 32'h3);
    cycle();
    check("rst_cfg_ie_off", 32'(intr), 32'h0);
    do_read(1'b0);
    do_read(1'b1);

`ifdef VDP_LINE_INT_MISS_COUNT_EN
    status_ch = 1'b0;
    do_write(1'b0, 69, 1'b1, 1'b0);
    for (int k = 0; k < 17; k++) do_line(69);
    cycle();
    check("miss_saturate", 32'(status_miss), 32'hF);
    do_read(1'b0);
    check("miss_read_value", 32'(status_miss), 32'hF);
    cycle();
    check("miss_cleared", 32'(status_miss), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
